pipe_ctrl: RTL
==============

# pipe_ctrl

Parametrised pipeline controller for the MIPS core, replacing the per-stage ad-hoc stall wiring in the CPU top with one block. It owns every stage-register hold/bubble signal and combines these sources: stall requests from any stage, load-use hazards from an internal load scoreboard, and precise exceptions with a PC-redirect handshake toward IF. It sits beside the pipeline in the top level and drives the `pc`, `id`, `ex`, `mm` and `wb` stage registers.

## Interface
- STAGES, 5, pipeline depth; stage 0 = IF, 1 = ID, 2 = EX, STAGES-1 = WB; minimum 4
- LOAD_LAT, 1, stages after EX before load data is bypassable; 1..STAGES-3
- REG_AW, 5, register address width
- SW, $clog2(STAGES), stage index width
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall_req  in  STAGES  stage i cannot complete this cycle
- id_rs, id_rt  in  REG_AW each  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1 each  the ID instruction reads that source
- id_load, id_dest  in  1, REG_AW  the ID instruction is a load, and its destination
- exc_valid  in  1  an exception is raised
- exc_stage  in  SW  stage raising the exception
- exc_vector  in  32  handler address
- redirect_ack  in  1  IF accepted the redirect
- hold  out  STAGES  stage-i input register (PC for i = 0) keeps its value
- bubble  out  STAGES  stage-i input register loads a NOP; bit 0 is always 0
- redirect_valid  out  1  a PC redirect is pending
- redirect_pc  out  32  redirect target
- stall_cycles, flush_events  out  32 each  performance counters

## Operation
- Effective stall index s = highest i with stall_req[i] = 1 or with the internal load-use request (mapped to i = 1).
  - hold[i] = 1 for every i ≤ s.
  - bubble[s+1] = 1 when s+1 < STAGES.
- Load scoreboard: LOAD_LAT entries of {valid, dest}.
  - Entry 0 loads {id_load, id_dest} when stage 2 neither holds nor bubbles.
  - Entry 0 clears when bubble[2] = 1.
  - Entry 0 keeps its value on hold[2].
  - Entry k follows entry k-1 under hold[2+k] / bubble[2+k].
- Load-use request: a valid entry with dest ≠ 0 that equals id_rs (with id_use_rs) or id_rt (with id_use_rt). Register 0 never creates a hazard.
- Exception FSM, state RUN:
  - On exc_valid with exc_stage = e: bubble[i] = 1 for 1 ≤ i ≤ e+1 (i < STAGES).
  - Latch exc_vector.
  - Go to REDIR.
- Exception FSM, state REDIR:
  - redirect_valid = 1; redirect_pc is the latched vector.
  - hold[0] = 1 and bubble[1] = 1.
  - On redirect_ack, return to RUN.
- Exception arriving in REDIR: accepted only if exc_stage exceeds the latched stage (the older instruction wins). It re-flushes, overwrites the vector and stays in REDIR.
- Priority, per bit: bubble overrides hold. Stall requests from stages above the flushed range still apply.

## Timing
- hold and bubble are combinational from the inputs and registered state; there is no added latency.
- The scoreboard and FSM update on the rising clk edge.
- Redirect latency: redirect_valid is asserted the cycle after exc_valid. It stays stable until the cycle redirect_ack is sampled high, and deasserts the following cycle.
- Reset values:
  - FSM in RUN, scoreboard cleared, redirect_valid 0, redirect_pc 0, counters 0.
  - hold and bubble are 0 with idle inputs.
- Asserting rst_n low mid-REDIR drops redirect_valid immediately and discards the pending vector.
- stall_req on all stages: hold is all ones, bubble is all zeros.

## Configuration
- PIPE_CTRL_PERF_EN defined: both counters are enabled and saturate at 32'hFFFF_FFFF.
  - stall_cycles increments each cycle hold[0] = 1.
  - flush_events increments once per accepted exception.
- PIPE_CTRL_PERF_EN undefined: the counters are not built; the ports remain and read constant 0.

## Structure
- Shared package `pipe_defs`:
  - stage index constants STG_IF, STG_ID, STG_EX, STG_MM, STG_WB;
  - FSM state encoding PC_RUN, PC_REDIR;
  - NOP instruction constant.
- Sub-module `load_scoreboard`: the LOAD_LAT-entry shift register and the hazard compare, producing the load-use request.

## Test plan
- Idle inputs, then stall_req = 5'b01000 → hold = 5'b01111, bubble = 5'b10000 for exactly the cycles stall_req is held.
- Load-use hazard: load r5 in ID, next ID instruction has id_rs = 5 with id_use_rs = 1 → one cycle of hold = 5'b00011, bubble = 5'b00100. The same sequence with r0 produces no stall.
- exc_valid with exc_stage = 3 and vector 32'hBFC0_0380 → same cycle bubble = 5'b11110. Next cycle redirect_valid = 1 with redirect_pc = 32'hBFC0_0380, held across 3 cycles with redirect_ack low. The cycle after redirect_ack is high, redirect_valid = 0.
- In REDIR with latched stage 2, exc_stage = 4 arrives → vector replaced, still in REDIR. A later exc_stage = 1 is ignored.
- Reset asserted while redirect_valid = 1 → redirect_valid = 0 immediately. After release there is no redirect and the scoreboard does not stall.
- With PIPE_CTRL_PERF_EN: 7 stall cycles and 2 exceptions → stall_cycles = 7, flush_events = 2. Without the macro both read 0.

Source files
------------

// File: rtl/pipe_defs.sv
// Shared definitions for the pipeline controller: stage indices, the
// exception FSM state encoding, the NOP constant and a saturating increment.
package pipe_defs;

  localparam int STG_IF = 0;
  localparam int STG_ID = 1;
  localparam int STG_EX = 2;
  localparam int STG_MM = 3;
  localparam int STG_WB = 4;

  typedef enum logic [0:0] {
    PC_RUN   = 1'b0,
    PC_REDIR = 1'b1
  } pc_state_e;

  localparam logic [31:0] NOP_INSN = 32'h0000_0000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    logic [31:0] res;
    if (val == 32'hFFFF_FFFF) begin
      res = val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pipe_ctrl_load_scoreboard.sv
// Load scoreboard: tracks loads in flight from EX until their data becomes
// bypassable and flags a load-use hazard against the ID instruction's sources.
// Entry k shadows stage EX+k and obeys that stage's hold/bubble controls.
module load_scoreboard
  import pipe_defs::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LOAD_LAT-1:0] sb_hold,
  input  logic [LOAD_LAT-1:0] sb_bubble,
  input  logic              id_load,
  input  logic [REG_AW-1:0] id_dest,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  output logic              lu_req
);

  logic [LOAD_LAT-1:0] vld_q, vld_d, src_vld_s;
  logic [REG_AW-1:0]   dst_q [LOAD_LAT];
  logic [REG_AW-1:0]   dst_d [LOAD_LAT];
  logic [REG_AW-1:0]   src_dst_s [LOAD_LAT];

  // Next-entry values: bubble clears, hold keeps, otherwise shift from upstream.
  always_comb begin
    src_vld_s[0] = id_load;
    src_dst_s[0] = id_dest;
    for (int k = 1; k < LOAD_LAT; k++) begin
      src_vld_s[k] = vld_q[k-1];
      src_dst_s[k] = dst_q[k-1];
    end
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (sb_bubble[k]) begin
        vld_d[k] = 1'b0;
        dst_d[k] = dst_q[k];
      end else if (sb_hold[k]) begin
        vld_d[k] = vld_q[k];
        dst_d[k] = dst_q[k];
      end else begin
        vld_d[k] = src_vld_s[k];
        dst_d[k] = src_dst_s[k];
      end
    end
  end

  // Hazard compare; a load to register 0 never blocks anything.
  always_comb begin
    lu_req = 1'b0;
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (vld_q[k] && (dst_q[k] != {REG_AW{1'b0}}) &&
          ((id_use_rs && (dst_q[k] == id_rs)) ||
           (id_use_rt && (dst_q[k] == id_rt)))) begin
        lu_req = 1'b1;
      end else begin
        lu_req = lu_req;
      end
    end
  end

  // Scoreboard entries register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= {LOAD_LAT{1'b0}};
      for (int k = 0; k < LOAD_LAT; k++) begin
        dst_q[k] <= {REG_AW{1'b0}};
      end
    end else begin
      vld_q <= vld_d;
      for (int k = 0; k < LOAD_LAT; k++) begin
        dst_q[k] <= dst_d[k];
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: merges stage stall requests, load-use hazards and
// precise exceptions into per-stage hold/bubble controls, and runs the
// PC-redirect handshake toward IF.
// Optional feature macro: PIPE_CTRL_PERF_EN builds the saturating
// stall_cycles / flush_events counters; without it both ports read 0.
module pipe_ctrl
  import pipe_defs::*;
#(
  parameter int STAGES   = 5,
  parameter int LOAD_LAT = 1,
  parameter int REG_AW   = 5,
  parameter int SW       = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [STAGES-1:0] stall_req,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              id_load,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              exc_valid,
  input  logic [SW-1:0]     exc_stage,
  input  logic [31:0]       exc_vector,
  input  logic              redirect_ack,
  output logic [STAGES-1:0] hold,
  output logic [STAGES-1:0] bubble,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_events
);

  logic              lu_req_s;
  logic              exc_acc_s;
  logic              seen_s;
  logic [STAGES-1:0] stall_vec_s, hold_stall_s, bubble_stall_s, bubble_exc_s;
  logic [STAGES-1:0] hold_s, bubble_s;

  pc_state_e         state_q, state_d;
  logic              rv_q, rv_d;
  logic [31:0]       rpc_q, rpc_d;
  logic [SW-1:0]     stg_q, stg_d;

  load_scoreboard #(
    .LOAD_LAT (LOAD_LAT),
    .REG_AW   (REG_AW)
  ) u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .sb_hold   (hold_s[STG_EX +: LOAD_LAT]),
    .sb_bubble (bubble_s[STG_EX +: LOAD_LAT]),
    .id_load   (id_load),
    .id_dest   (id_dest),
    .id_rs     (id_rs),
    .id_rt     (id_rt),
    .id_use_rs (id_use_rs),
    .id_use_rt (id_use_rt),
    .lu_req    (lu_req_s)
  );

  // Stall merge: hold every stage at or below the highest stalled one and
  // insert a bubble just above it.
  always_comb begin
    stall_vec_s         = stall_req;
    stall_vec_s[STG_ID] = stall_req[STG_ID] | lu_req_s;
    seen_s              = 1'b0;
    hold_stall_s        = {STAGES{1'b0}};
    bubble_stall_s      = {STAGES{1'b0}};
    for (int i = STAGES - 1; i >= 0; i--) begin
      seen_s          = seen_s | stall_vec_s[i];
      hold_stall_s[i] = seen_s;
    end
    for (int i = 1; i < STAGES; i++) begin
      bubble_stall_s[i] = hold_stall_s[i-1] & ~hold_stall_s[i];
    end
  end

  // Exception acceptance (older instruction wins while a redirect is pending)
  // and the flush of every stage younger than or at the faulting one.
  always_comb begin
    if (!exc_valid) begin
      exc_acc_s = 1'b0;
    end else if (state_q == PC_RUN) begin
      exc_acc_s = 1'b1;
    end else begin
      exc_acc_s = (exc_stage > stg_q);
    end
    bubble_exc_s = {STAGES{1'b0}};
    for (int i = 1; i < STAGES; i++) begin
      if (exc_acc_s && (i <= int'(exc_stage) + 1)) begin
        bubble_exc_s[i] = 1'b1;
      end else begin
        bubble_exc_s[i] = 1'b0;
      end
    end
  end

  // Final controls: redirect freezes the PC and starves ID; bubble beats hold.
  always_comb begin
    hold_s   = hold_stall_s;
    bubble_s = bubble_stall_s | bubble_exc_s;
    if (state_q == PC_REDIR) begin
      hold_s[STG_IF]   = 1'b1;
      bubble_s[STG_ID] = 1'b1;
    end else begin
      hold_s[STG_IF]   = hold_stall_s[STG_IF];
      bubble_s[STG_ID] = bubble_s[STG_ID];
    end
    bubble_s[STG_IF] = 1'b0;
    hold_s           = hold_s & ~bubble_s;
  end

  assign hold   = hold_s;
  assign bubble = bubble_s;

  // Exception FSM next state: latch vector/stage on accept, leave on ack.
  always_comb begin
    state_d = state_q;
    rv_d    = rv_q;
    rpc_d   = rpc_q;
    stg_d   = stg_q;
    case (state_q)
      PC_RUN, PC_REDIR: begin
        if (exc_acc_s) begin
          state_d = PC_REDIR;
          rv_d    = 1'b1;
          rpc_d   = exc_vector;
          stg_d   = exc_stage;
        end else if ((state_q == PC_REDIR) && redirect_ack) begin
          state_d = PC_RUN;
          rv_d    = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = PC_RUN;
        rv_d    = 1'b0;
      end
    endcase
  end

  // Exception FSM state and registered redirect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PC_RUN;
      rv_q    <= 1'b0;
      rpc_q   <= 32'h0000_0000;
      stg_q   <= {SW{1'b0}};
    end else begin
      state_q <= state_d;
      rv_q    <= rv_d;
      rpc_q   <= rpc_d;
      stg_q   <= stg_d;
    end
  end

  assign redirect_valid = rv_q;
  assign redirect_pc    = rpc_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  // Counter next values: PC-held cycles and accepted exceptions, saturating.
  always_comb begin
    if (hold_s[STG_IF]) begin
      stall_cnt_d = sat_inc32(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (exc_acc_s) begin
      flush_cnt_d = sat_inc32(flush_cnt_q);
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Performance counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'h0000_0000;
      flush_cnt_q <= 32'h0000_0000;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign flush_events = flush_cnt_q;
`else
  assign stall_cycles = 32'h0000_0000;
  assign flush_events = 32'h0000_0000;
`endif

endmodule
